qspi_seq: RTL
=============

# qspi_seq

Table-driven QSPI transaction sequencer; parametrised successor to the fixed-opcode QSPI interface. Sits between the QSPI shift engine (SPI clock domain) and the bridge controller (system domain). Per transaction it decodes the opcode against a runtime-programmable command table. The table sets the address phase, dummy cycles, lane width and data direction. Continuous reads and writes auto-increment the address.

## Interface
- CMD_BITS, 8, opcode width (≤8)
- ADDR_BITS, 24, address width; ADDR_RND = 8·ceil(ADDR_BITS/8)
- DATA_BITS, 16, data word width; DATA_RND = 8·ceil(DATA_BITS/8); STEP = DATA_RND/8
- NCMD, 4, command table entries (power of 2, ≥2)
- WAIT_CYC, 10, reset dummy-cycle count for entry 1
- IOREG_BITS, 32, shift-engine data register width
- CYCLE_COUNT_BITS, 8, width of o_txnbc

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_txndone  in  1  word-done level from SPI domain (async)
- i_txnreset  in  1  CE deasserted (async)
- i_txndata  in  IOREG_BITS  received word
- o_txndata  out  IOREG_BITS  {zeros, i_spidata}
- o_txnbc  out  CYCLE_COUNT_BITS  bit count of current phase
- o_txndir  out  1  0 = receive, 1 = drive
- o_txnlanes  out  2  00 = x1, 01 = x2, 10 = x4
- i_cfg_we  in  1  table write strobe
- i_cfg_idx  in  log2(NCMD)  entry index
- i_cfg_data  in  24  entry: [7:0] opcode, [8] has_addr, [10:9] data mode (00 none, 01 read, 10 write), [12:11] lanes, [13] valid, [23:16] wait cycles
- o_spirst  out  1  synchronised i_txnreset
- o_spistbcmd / o_spistbadr / o_spistbrrq / o_spistbwrq  out  1 each  one-cycle strobes
- o_spistate  out  3  current state
- o_spicmd  out  CMD_BITS  latched opcode
- o_spiaddr  out  ADDR_BITS  current address
- o_spidata  out  DATA_BITS  latched write data
- i_spidata  in  DATA_BITS  read data from controller
- o_badcmd  out  1  sticky unmatched-opcode flag, cleared by i_rst

## Operation
- States: CMD=0, ADDR=1, STALL=2, READ=3, WRITE=4, ERR=5. State advances only on wstb_pe, the rising edge of i_txndone after 2-flop synchronisation. o_spirst (reset value 1) or i_rst forces CMD.
- Phase config by state:
  - CMD: bc = CMD_BITS, dir 0, lanes x4.
  - ADDR: bc = ADDR_RND, dir 0.
  - STALL: bc = wait × lanes-bits (1/2/4), dir 0.
  - READ: bc = DATA_RND, dir 1.
  - WRITE: bc = DATA_RND, dir 0.
  - ERR: bc = 8, dir 0, lanes x4.
  - Non-CMD/ERR states use the latched entry's lanes.
- CMD pe: latch opcode from i_txndata[7:0]. Match it against valid entries; the lowest index wins. Latch the matched entry into an active-entry register. On no match: go to ERR and set o_badcmd. ERR stays in ERR until o_spirst.
- Transitions:
  - From CMD: ADDR if has_addr; else STALL if wait≠0; else READ/WRITE by mode; mode none → CMD.
  - From ADDR: STALL if wait≠0, else READ/WRITE by mode; mode none → CMD.
  - From STALL: READ/WRITE by mode.
  - READ→READ; WRITE→WRITE.
- Strobes are registered one cycle after pe:
  - cmd: pe in CMD with a match.
  - adr: pe in ADDR.
  - rrq: pe whose next state is STALL or READ (including READ→READ).
  - wrq: pe in WRITE.
- Address:
  - Latched at ADDR pe.
  - On pe in READ, the address increments by STEP in the same cycle, so the following rrq sees the next word's address.
  - In WRITE, the address increments by STEP in the cycle o_spistbwrq is high.
  - Wraps modulo 2^ADDR_BITS.
- Write data: latched from i_txndata[DATA_BITS-1:0] at pe in WRITE.
- Table reset contents:
  - entry 0: 0x03, addr, read, x4, wait 0.
  - entry 1: 0x0B, addr, read, x4, wait WAIT_CYC.
  - entry 2: 0x02, addr, write, x4.
  - other entries: invalid.
- Table writes are allowed at any time and take effect from the next CMD decode. A write in the same cycle as the decode is not seen by that decode.
- o_spirst mid-transaction: state → CMD; cmd/addr/data/table/o_badcmd retained.

## Timing
- Synchroniser plus edge detect: wstb_pe is high 3 i_clk cycles after i_txndone rises, for 1 cycle. Strobes follow one cycle later.
- i_txndone must stay low ≥3 i_clk cycles between words.
- o_txnbc/dir/lanes are combinational from state and the active entry. They are valid from the cycle the state changes.
- Reset values:
  - state CMD; strobes 0; o_spirst 1; o_badcmd 0.
  - o_spicmd/o_spiaddr/o_spidata 0; active entry = entry 0.

## Structure
- A shared header holds the state encodings, the table field offsets, the lane codes and the reset entry constants.
- Natural sub-module: qspi_cmd_table, holding NCMD registers, the write port and a priority match returning {hit, entry}.
- Synchronisers reuse the existing two-flop sync cells.

## Test plan
- Opcode 0x03, addr 0x001234, three read words → one rrq after ADDR, then rrq with addresses 0x001236 and 0x001238; bc sequence 8, 24, 16, 16, 16.
- Opcode 0x0B → STALL with bc 40 (10×4), then READ dir 1; rrq fires on ADDR→STALL.
- Opcode 0x02, addr 0xFFFFFE, write 0xAAAA then 0x5555 → wrq with addr 0xFFFFFE, then wrq with addr 0x000000 (wrap).
- Program entry 3 = 0x6B, x2 lanes, wait 8 → STALL bc 16, lanes 01. Opcode 0x55 → ERR, o_badcmd 1, no cmd strobe.
- i_txnreset pulsed mid-READ → state CMD within 3 cycles, address retained; next 0x03 decodes normally.
- Table write to entry 0 in the same cycle as a CMD pe → that decode uses the old entry, the next transaction uses the new one.

Source files
------------

// File: rtl/qspi_seq_pkg.sv
// qspi_seq_pkg: definitions shared by the QSPI transaction sequencer.
// Holds the state encodings, the command-table entry layout (field
// offsets are fixed by the packed struct order), lane and data-mode codes,
// and the reset contents of the command table.
package qspi_seq_pkg;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_STALL = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  localparam logic [1:0] LANE_X1 = 2'b00;
  localparam logic [1:0] LANE_X2 = 2'b01;
  localparam logic [1:0] LANE_X4 = 2'b10;

  // Entry layout, MSB first: [23:16] wait, [15:14] reserved, [13] valid,
  // [12:11] lanes, [10:9] data mode, [8] has_addr, [7:0] opcode.
  typedef struct packed {
    logic [7:0] wait_cyc;
    logic [1:0] rsvd;
    logic       valid;
    logic [1:0] lanes;
    logic [1:0] mode;
    logic       has_addr;
    logic [7:0] opcode;
  } entry_t;

  localparam entry_t ENTRY0_RST = '{wait_cyc: 8'd0, rsvd: 2'b00, valid: 1'b1,
                                    lanes: LANE_X4, mode: MODE_READ,
                                    has_addr: 1'b1, opcode: 8'h03};
  // The wait field of entry 1 is filled from WAIT_CYC by the table.
  localparam entry_t ENTRY1_RST = '{wait_cyc: 8'd0, rsvd: 2'b00, valid: 1'b1,
                                    lanes: LANE_X4, mode: MODE_READ,
                                    has_addr: 1'b1, opcode: 8'h0B};
  localparam entry_t ENTRY2_RST = '{wait_cyc: 8'd0, rsvd: 2'b00, valid: 1'b1,
                                    lanes: LANE_X4, mode: MODE_WRITE,
                                    has_addr: 1'b1, opcode: 8'h02};

  // Bits moved per SPI clock for a lane code; reserved code 11 acts as x4.
  function automatic int lane_bits(input logic [1:0] lanes);
    case (lanes)
      LANE_X1: return 1;
      LANE_X2: return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/qspi_seq_if.sv
// qspi_seq_if: bundles the shift-engine side (txn*), the bridge-controller
// side (spi*) and the command-table write port of the sequencer.
//   master : the sequencer's view (drives the o_* signals)
//   slave  : the surrounding logic's view (drives the i_* signals)
interface qspi_seq_if #(
  parameter int CMD_BITS         = 8,
  parameter int ADDR_BITS        = 24,
  parameter int DATA_BITS        = 16,
  parameter int NCMD             = 4,
  parameter int IOREG_BITS       = 32,
  parameter int CYCLE_COUNT_BITS = 8
);

  logic                        i_txndone;
  logic                        i_txnreset;
  logic [IOREG_BITS-1:0]       i_txndata;
  logic [IOREG_BITS-1:0]       o_txndata;
  logic [CYCLE_COUNT_BITS-1:0] o_txnbc;
  logic                        o_txndir;
  logic [1:0]                  o_txnlanes;

  logic                        i_cfg_we;
  logic [$clog2(NCMD)-1:0]     i_cfg_idx;
  logic [23:0]                 i_cfg_data;

  logic                        o_spirst;
  logic                        o_spistbcmd;
  logic                        o_spistbadr;
  logic                        o_spistbrrq;
  logic                        o_spistbwrq;
  logic [2:0]                  o_spistate;
  logic [CMD_BITS-1:0]         o_spicmd;
  logic [ADDR_BITS-1:0]        o_spiaddr;
  logic [DATA_BITS-1:0]        o_spidata;
  logic [DATA_BITS-1:0]        i_spidata;
  logic                        o_badcmd;

  modport master (
    input  i_txndone, i_txnreset, i_txndata,
    output o_txndata, o_txnbc, o_txndir, o_txnlanes,
    input  i_cfg_we, i_cfg_idx, i_cfg_data,
    output o_spirst, o_spistbcmd, o_spistbadr, o_spistbrrq, o_spistbwrq,
    output o_spistate, o_spicmd, o_spiaddr, o_spidata,
    input  i_spidata,
    output o_badcmd
  );

  modport slave (
    output i_txndone, i_txnreset, i_txndata,
    input  o_txndata, o_txnbc, o_txndir, o_txnlanes,
    output i_cfg_we, i_cfg_idx, i_cfg_data,
    input  o_spirst, o_spistbcmd, o_spistbadr, o_spistbrrq, o_spistbwrq,
    input  o_spistate, o_spicmd, o_spiaddr, o_spidata,
    output i_spidata,
    input  o_badcmd
  );

endinterface

// File: rtl/qspi_cmd_table.sv
// qspi_cmd_table: runtime-programmable opcode table.
//   i_clk, i_rst   : clock, synchronous active-high reset (restores defaults)
//   i_we/i_idx/i_wdata : entry write port, takes effect at the clock edge
//   i_opcode       : opcode to look up
//   o_hit/o_entry  : lowest-index valid entry whose opcode matches
// The lookup reads the registered table, so a write landing on the same
// edge as a decode is not seen by that decode.
module qspi_cmd_table import qspi_seq_pkg::*; #(
  parameter int NCMD     = 4,
  parameter int CMD_BITS = 8,
  parameter int WAIT_CYC = 10,
  parameter int IDX_W    = $clog2(NCMD)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_idx,
  input  entry_t              i_wdata,
  input  logic [CMD_BITS-1:0] i_opcode,
  output logic                o_hit,
  output entry_t              o_entry
);

  entry_t tbl [NCMD];

  function automatic entry_t rst_entry(input int idx);
    entry_t e;
    case (idx)
      0: e = ENTRY0_RST;
      1: begin
        e          = ENTRY1_RST;
        e.wait_cyc = 8'(WAIT_CYC);
      end
      2: e = ENTRY2_RST;
      default: e = '0;
    endcase
    return e;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NCMD; i++) tbl[i] <= rst_entry(i);
    end else if (i_we) begin
      tbl[i_idx] <= i_wdata;
    end
  end

  // Scan from the top so the lowest matching index is the one that sticks.
  always_comb begin
    o_hit   = 1'b0;
    o_entry = '0;
    for (int i = NCMD - 1; i >= 0; i--) begin
      if (tbl[i].valid && (tbl[i].opcode[CMD_BITS-1:0] == i_opcode)) begin
        o_hit   = 1'b1;
        o_entry = tbl[i];
      end
    end
  end

endmodule

// File: rtl/qspi_seq.sv
// qspi_seq: table-driven QSPI transaction sequencer.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   bus          : qspi_seq_if.master
//     txn* side  : word-done / CE-deassert levels from the SPI domain,
//                  received word, and per-phase bit count, direction, lanes
//     cfg*       : command-table write port
//     spi* side  : strobes, state, opcode, address and write data to the
//                  bridge controller, read data back from it
//     o_badcmd   : sticky unmatched-opcode flag
// Every received word advances the FSM once, on the synchronised rising
// edge of i_txndone. The phase shape (bit count, direction, lanes) is a
// pure function of the state and the latched table entry.
module qspi_seq import qspi_seq_pkg::*; #(
  parameter int CMD_BITS         = 8,
  parameter int ADDR_BITS        = 24,
  parameter int DATA_BITS        = 16,
  parameter int NCMD             = 4,
  parameter int WAIT_CYC         = 10,
  parameter int IOREG_BITS       = 32,
  parameter int CYCLE_COUNT_BITS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  qspi_seq_if.master bus
);

  localparam int ADDR_RND = 8 * ((ADDR_BITS + 7) / 8);
  localparam int DATA_RND = 8 * ((DATA_BITS + 7) / 8);
  localparam int STEP     = DATA_RND / 8;
  localparam int IDX_W    = $clog2(NCMD);

  logic done_p0, done_p1, done_p2;
  logic rst_p0, rst_p1;
  logic wstb_pe;
  logic pe_ok;

  state_t state_q, state_d;
  entry_t act_q;
  entry_t match_entry;
  logic   hit;

  logic cmd_stb_d, adr_stb_d, rrq_stb_d, wrq_stb_d;
  logic cmd_stb_p4, adr_stb_p4, rrq_stb_p4, wrq_stb_p4;

  logic [CMD_BITS-1:0]         cmd_q;
  logic [ADDR_BITS-1:0]        addr_q;
  logic [DATA_BITS-1:0]        wdata_q;
  logic                        badcmd_q;
  logic [CYCLE_COUNT_BITS-1:0] bc;
  logic                        dir;
  logic [1:0]                  lanes;
  logic                        unused_bits;

  function automatic state_t data_state(input logic [1:0] mode);
    case (mode)
      MODE_READ:  return ST_READ;
      MODE_WRITE: return ST_WRITE;
      default:    return ST_CMD;
    endcase
  endfunction

  qspi_cmd_table #(
    .NCMD     (NCMD),
    .CMD_BITS (CMD_BITS),
    .WAIT_CYC (WAIT_CYC),
    .IDX_W    (IDX_W)
  ) u_table (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (bus.i_cfg_we),
    .i_idx    (bus.i_cfg_idx),
    .i_wdata  (entry_t'(bus.i_cfg_data)),
    .i_opcode (bus.i_txndata[CMD_BITS-1:0]),
    .o_hit    (hit),
    .o_entry  (match_entry)
  );

  // Stage p0..p2: two-flop synchronisers for the SPI-domain levels plus one
  // history flop for the done edge. o_spirst starts asserted so nothing is
  // decoded until CE has been seen deasserted-then-released cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      done_p0 <= 1'b0;
      done_p1 <= 1'b0;
      done_p2 <= 1'b0;
      rst_p0  <= 1'b1;
      rst_p1  <= 1'b1;
      wstb_pe <= 1'b0;
    end else begin
      done_p0 <= bus.i_txndone;
      done_p1 <= done_p0;
      done_p2 <= done_p1;
      rst_p0  <= bus.i_txnreset;
      rst_p1  <= rst_p0;
      wstb_pe <= done_p1 & ~done_p2;
    end
  end

  // A word boundary that coincides with CE deassertion is discarded.
  assign pe_ok = wstb_pe & ~rst_p1;

  always_comb begin
    state_d   = state_q;
    cmd_stb_d = 1'b0;
    adr_stb_d = 1'b0;
    rrq_stb_d = 1'b0;
    wrq_stb_d = 1'b0;
    if (pe_ok) begin
      case (state_q)
        ST_CMD: begin
          if (!hit)                          state_d = ST_ERR;
          else if (match_entry.has_addr)     state_d = ST_ADDR;
          else if (match_entry.wait_cyc != 0) state_d = ST_STALL;
          else                               state_d = data_state(match_entry.mode);
        end
        ST_ADDR: begin
          if (act_q.wait_cyc != 0) state_d = ST_STALL;
          else                     state_d = data_state(act_q.mode);
        end
        ST_STALL: state_d = data_state(act_q.mode);
        ST_READ, ST_WRITE, ST_ERR: state_d = state_q;
        default: state_d = ST_CMD;
      endcase
      cmd_stb_d = (state_q == ST_CMD) && hit;
      adr_stb_d = (state_q == ST_ADDR);
      // The read request goes out as early as possible: already on entry to
      // the dummy phase, so the controller has the whole stall to fetch.
      rrq_stb_d = (state_d == ST_STALL) || (state_d == ST_READ);
      wrq_stb_d = (state_q == ST_WRITE);
    end
  end

  // Stage p3 -> p4: state update and registered controller strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst || rst_p1) state_q <= ST_CMD;
    else                 state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_stb_p4 <= 1'b0;
      adr_stb_p4 <= 1'b0;
      rrq_stb_p4 <= 1'b0;
      wrq_stb_p4 <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      act_q      <= ENTRY0_RST;
      badcmd_q   <= 1'b0;
    end else begin
      cmd_stb_p4 <= cmd_stb_d;
      adr_stb_p4 <= adr_stb_d;
      rrq_stb_p4 <= rrq_stb_d;
      wrq_stb_p4 <= wrq_stb_d;

      if (pe_ok && (state_q == ST_CMD)) begin
        cmd_q <= bus.i_txndata[CMD_BITS-1:0];
        if (hit) act_q    <= match_entry;
        else     badcmd_q <= 1'b1;
      end

      // Reads advance on the word edge so the accompanying rrq already
      // carries the next address; writes advance after the wrq cycle so
      // the controller sees the address the data belongs to.
      if (pe_ok && (state_q == ST_ADDR))
        addr_q <= bus.i_txndata[ADDR_BITS-1:0];
      else if (pe_ok && (state_q == ST_READ))
        addr_q <= addr_q + ADDR_BITS'(STEP);
      else if (wrq_stb_p4)
        addr_q <= addr_q + ADDR_BITS'(STEP);

      if (pe_ok && (state_q == ST_WRITE))
        wdata_q <= bus.i_txndata[DATA_BITS-1:0];
    end
  end

  always_comb begin
    bc    = CYCLE_COUNT_BITS'(CMD_BITS);
    dir   = 1'b0;
    lanes = act_q.lanes;
    case (state_q)
      ST_CMD:   lanes = LANE_X4;
      ST_ADDR:  bc = CYCLE_COUNT_BITS'(ADDR_RND);
      ST_STALL: bc = CYCLE_COUNT_BITS'(int'(act_q.wait_cyc) * lane_bits(act_q.lanes));
      ST_READ: begin
        bc  = CYCLE_COUNT_BITS'(DATA_RND);
        dir = 1'b1;
      end
      ST_WRITE: bc = CYCLE_COUNT_BITS'(DATA_RND);
      ST_ERR: begin
        bc    = CYCLE_COUNT_BITS'(8);
        lanes = LANE_X4;
      end
      default:  lanes = LANE_X4;
    endcase
  end

  assign bus.o_txndata   = {{(IOREG_BITS-DATA_BITS){1'b0}}, bus.i_spidata};
  assign bus.o_txnbc     = bc;
  assign bus.o_txndir    = dir;
  assign bus.o_txnlanes  = lanes;
  assign bus.o_spirst    = rst_p1;
  assign bus.o_spistbcmd = cmd_stb_p4;
  assign bus.o_spistbadr = adr_stb_p4;
  assign bus.o_spistbrrq = rrq_stb_p4;
  assign bus.o_spistbwrq = wrq_stb_p4;
  assign bus.o_spistate  = state_q;
  assign bus.o_spicmd    = cmd_q;
  assign bus.o_spiaddr   = addr_q;
  assign bus.o_spidata   = wdata_q;
  assign bus.o_badcmd    = badcmd_q;

  assign unused_bits = ^{bus.i_txndata[IOREG_BITS-1:ADDR_BITS], act_q.rsvd,
                         act_q.valid, act_q.has_addr, act_q.opcode};

endmodule
